// File: rtl/skew_in_feeder.sv
// Skews one matrix row per accepted beat onto the systolic-array edge: column c
// sees its element c cycles after column 0, with a short drain phase per matrix.
module skew_in_feeder #(
   parameter int unsigned SA_SIZE         = 8,
   parameter int unsigned ACTIVATION_SIZE = 32
) (
   input  logic                                 clk,
   input  logic                                 resetn,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [SA_SIZE*ACTIVATION_SIZE-1:0]   in_data,
   input  logic                                 in_last,
   output logic [SA_SIZE*ACTIVATION_SIZE-1:0]   out,
   output logic [SA_SIZE-1:0]                   out_valid,
   output logic                                 busy,
   output logic                                 done
);

   localparam int unsigned CNT_W = $clog2(SA_SIZE);
   localparam int unsigned EW    = ACTIVATION_SIZE + 1;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   drain_cnt_q;
   logic               in_ready_q;
   logic               busy_q;
   logic               done_q;
   logic               accept;

   assign accept    = in_valid & in_ready_q;
   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;

   // Matrix framing: stream rows until in_last, then hold off input until the
   // last row's final column has reached the array edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         drain_cnt_q <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, STREAM: begin
               if (accept) begin
                  busy_q <= 1'b1;
                  if (in_last) begin
                     state_q     <= DRAIN;
                     drain_cnt_q <= CNT_W'(SA_SIZE - 2);
                     in_ready_q  <= 1'b0;
                  end else begin
                     state_q <= STREAM;
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt_q == '0) begin
                  state_q    <= IDLE;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
               end else begin
                  drain_cnt_q <= drain_cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b1;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   // Column c is a free-running (c+1)-deep pipe of {valid, data}; idle beats
   // enter as zero bubbles so later rows keep their diagonal alignment.
   for (genvar c = 0; c < SA_SIZE; c++) begin : g_col
      logic [EW-1:0] load;
      logic [EW-1:0] tail;

      assign load = accept ? {1'b1, in_data[c*ACTIVATION_SIZE +: ACTIVATION_SIZE]} : '0;

      if (c == 0) begin : g_one
         logic [EW-1:0] stage_q;
         always_ff @(posedge clk) begin
            if (!resetn) stage_q <= '0;
            else         stage_q <= load;
         end
         assign tail = stage_q;
      end else begin : g_multi
         logic [EW-1:0] stage_q [c+1];
         always_ff @(posedge clk) begin
            if (!resetn) begin
               for (int s = 0; s <= c; s++) stage_q[s] <= '0;
            end else begin
               stage_q[0] <= load;
               for (int s = 1; s <= c; s++) stage_q[s] <= stage_q[s-1];
            end
         end
         assign tail = stage_q[c];
      end

      assign out[c*ACTIVATION_SIZE +: ACTIVATION_SIZE] = tail[ACTIVATION_SIZE-1:0];
      assign out_valid[c]                               = tail[ACTIVATION_SIZE];
   end

endmodule

// File: tb/tb_skew_in_feeder.sv
// Scoreboard bench for skew_in_feeder (SA_SIZE=4): per-column arrival time/data,
// framing outputs, and row realignment through a behavioural output deskew.
module tb_skew_in_feeder;

   localparam int unsigned SA    = 4;
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = SA * AW;
   localparam int          NEVER = 1 << 30;

   logic          clk      = 1'b0;
   logic          resetn   = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last  = 1'b0;
   logic [DW-1:0] in_data  = '0;
   logic          in_ready;
   logic [DW-1:0] out;
   logic [SA-1:0] out_valid;
   logic          busy;
   logic          done;

   skew_in_feeder #(.SA_SIZE(SA), .ACTIVATION_SIZE(AW)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // e = number of rising edges so far = index of the next edge
   int e = 0;
   always @(posedge clk) e <= e + 1;

   typedef struct {logic [AW-1:0] d; int t;} col_ent_t;
   typedef struct {logic [DW-1:0] d; int t;} row_ent_t;

   col_ent_t colq [SA][$];
   row_ent_t rowq [$];
   int       doneq [$];
   int       busy_from = NEVER;
   int       busy_to   = NEVER;
   int       rdy_from  = NEVER;
   int       rdy_to    = -1;
   bit       first_row = 1'b1;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mkrow(input int b);
      logic [DW-1:0] r;
      for (int c = 0; c < SA; c++) r[c*AW +: AW] = AW'(b + c);
      return r;
   endfunction

   // Drive one beat for the next edge; on acceptance push all expectations.
   task automatic drive(input logic v, input logic last, input logic [DW-1:0] d, output bit acc);
      @(posedge clk);
      #1;
      in_valid = v;
      in_last  = last;
      in_data  = d;
      acc      = v && in_ready;
      if (acc) begin
         for (int c = 0; c < SA; c++) colq[c].push_back('{d: d[c*AW +: AW], t: e + c + 1});
         rowq.push_back('{d: d, t: e + SA + 1});
         if (first_row) begin
            busy_from = e + 1;
            busy_to   = NEVER;
         end
         first_row = last;
         if (last) begin
            busy_to  = e + SA;
            rdy_from = e + 1;
            rdy_to   = e + SA - 1;
            doneq.push_back(e + SA);
         end
      end
   endtask

   task automatic idle(input int n);
      bit a;
      repeat (n) drive(1'b0, 1'b0, '0, a);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      resetn   = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int c = 0; c < SA; c++) colq[c].delete();
      rowq.delete();
      doneq.delete();
      first_row = 1'b1;
      busy_from = NEVER;
      busy_to   = NEVER;
      rdy_from  = NEVER;
      rdy_to    = -1;
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   // Behavioural output deskew: column c delayed a further SA-c cycles.
   logic [AW:0] dsk [SA][SA];
   always @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < SA; i++)
            for (int j = 0; j < SA; j++) dsk[i][j] <= '0;
      end else begin
         for (int c = 0; c < SA; c++) begin
            dsk[c][0] <= {out_valid[c], out[c*AW +: AW]};
            for (int k = 1; k < SA; k++) dsk[c][k] <= dsk[c][k-1];
         end
      end
   end

   always @(negedge clk) begin : mon
      col_ent_t      ce;
      row_ent_t      re;
      logic [AW-1:0] v;
      logic [DW-1:0] rowd;
      bit            any_v;
      bit            all_v;
      bit            exp_done;
      if (resetn) begin
         for (int c = 0; c < SA; c++) begin
            v = out[c*AW +: AW];
            if (out_valid[c]) begin
               if (colq[c].size() == 0) begin
                  chk($sformatf("col%0d_spurious_valid", c), out_valid[c], 1'b0);
               end else begin
                  ce = colq[c].pop_front();
                  chk($sformatf("col%0d_data", c), v, ce.d);
                  chk($sformatf("col%0d_time", c), e, ce.t);
               end
            end else begin
               chk($sformatf("col%0d_bubble_zero", c), v, '0);
               if (colq[c].size() != 0 && e > colq[c][0].t) begin
                  ce = colq[c].pop_front();
                  chk($sformatf("col%0d_missing", c), out_valid[c], 1'b1);
               end
            end
         end
         exp_done = (doneq.size() != 0) && (doneq[0] == e);
         chk("done", done, exp_done);
         if (exp_done) void'(doneq.pop_front());
         chk("busy", busy, (e >= busy_from) && (e < busy_to));
         chk("in_ready", in_ready, !((e >= rdy_from) && (e <= rdy_to)));
         any_v = 1'b0;
         all_v = 1'b1;
         for (int c = 0; c < SA; c++) begin
            any_v = any_v | dsk[c][SA-1-c][AW];
            all_v = all_v & dsk[c][SA-1-c][AW];
            rowd[c*AW +: AW] = dsk[c][SA-1-c][AW-1:0];
         end
         if (any_v) begin
            if (!all_v) begin
               chk("deskew_row_aligned", all_v, 1'b1);
            end else if (rowq.size() == 0) begin
               chk("deskew_row_spurious", all_v, 1'b0);
            end else begin
               re = rowq.pop_front();
               chk("deskew_row_data", rowd, re.d);
               chk("deskew_row_latency", e, re.t);
            end
         end
      end
   end

   initial begin
      bit            acc;
      int            cnt;
      int            e_a;
      logic [DW-1:0] r;

      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_out", out, '0);
      chk("rst_out_valid", out_valid, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);

      // single-row matrix straight from IDLE to DRAIN
      drive(1'b1, 1'b1, mkrow(1), acc);
      chk("single_accept", acc, 1'b1);
      idle(6);

      // four back-to-back rows
      for (int k = 0; k < 4; k++) drive(1'b1, k == 3, mkrow(10 * k), acc);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         idle(1);
         if (!in_ready) cnt++;
      end
      chk("ready_low_cycles", cnt, 3);
      chk("busy_after_done", busy, 1'b0);

      // two bubbles between rows
      drive(1'b1, 1'b0, mkrow(100), acc);
      idle(2);
      drive(1'b1, 1'b1, mkrow(200), acc);
      idle(6);

      // valid held through DRAIN is only taken once IDLE returns
      drive(1'b1, 1'b1, mkrow(300), acc);
      e_a = e;
      for (int c = 0; c < SA; c++) r[c*AW +: AW] = 32'hDEAD;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) drive(1'b1, 1'b1, r, acc);
      chk("dead_accepted", acc, 1'b1);
      chk("dead_accept_edge", e, e_a + SA);
      idle(6);

      // reset while draining with two rows in flight
      drive(1'b1, 1'b0, mkrow(400), acc);
      drive(1'b1, 1'b1, mkrow(500), acc);
      do_reset();
      @(negedge clk);
      chk("midrst_out_valid", out_valid, '0);
      chk("midrst_out", out, '0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_done", done, 1'b0);
      idle(8);

      // random six-row matrix
      for (int k = 0; k < 6; k++) begin
         for (int c = 0; c < SA; c++) r[c*AW +: AW] = $urandom;
         drive(1'b1, k == 5, r, acc);
         chk("rand_accept", acc, 1'b1);
      end
      idle(SA + 4);

      cnt = rowq.size() + doneq.size();
      for (int c = 0; c < SA; c++) cnt += colq[c].size();
      chk("scoreboard_empty", cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
